ifu_fetch_queue: RTL
====================

Name: ifu_fetch_queue

Overview:
- Fetch stage directly downstream of the program counter.
- Takes the current PC and its valid, issues in-order instruction-memory requests, and pairs each returned instruction with its PC in a DEPTH-entry queue.
- Presents {pc, instr} to decode with a valid/ready handshake and drives the PC stall.
- Flush discards all queued and in-flight fetches; used on branch redirect.

Parameters:
PC_WIDTH, 32, width of PC and memory address
INSTR_WIDTH, 32, width of instruction word
DEPTH, 4, queue entries; power of 2, >= 2

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
pc_in  in  PC_WIDTH  current PC from program counter
pc_in_valid  in  1  pc_in is a fetch candidate this cycle
pc_stall  out  1  to PC stall input; PC must hold
flush  in  1  discard all queued and outstanding fetches
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  PC_WIDTH  fetch address (= pc_in)
imem_req_ready  in  1  memory accepts request; must not depend on imem_req_valid
imem_rsp_valid  in  1  in-order response; no backpressure
imem_rsp_data  in  INSTR_WIDTH  instruction word
dec_valid  out  1  head entry valid to decode
dec_pc  out  PC_WIDTH  head entry PC
dec_instr  out  INSTR_WIDTH  head entry instruction
dec_ready  in  1  decode consumes head

Behaviour:
- State:
  - Entry arrays pc_q[DEPTH] and instr_q[DEPTH].
  - Pointers alloc_ptr, fill_ptr, rd_ptr, each clog2(DEPTH)+1 bits, wrapping naturally; MSB disambiguates full from empty.
  - drop_cnt, clog2(DEPTH)+2 bits.
- Derived:
  - occ = alloc_ptr - rd_ptr; full = (occ == DEPTH).
  - outstanding = alloc_ptr - fill_ptr.
  - Head ready = (rd_ptr != fill_ptr).
- Issue:
  - imem_req_valid = pc_in_valid & ~full & ~flush & ~rst.
  - req_fire = imem_req_valid & imem_req_ready.
  - On req_fire: pc_q[alloc] <= pc_in; alloc_ptr++.
- PC stall: pc_stall = rst | flush | full | ~imem_req_ready. This is combinational, so the PC advances exactly on cycles where a request can fire.
- Response:
  - rsp_valid with drop_cnt != 0 (and no flush): discard; drop_cnt--.
  - Otherwise: instr_q[fill] <= data; fill_ptr++.
  - A response with outstanding == 0 and drop_cnt == 0 is a protocol error (ignored; assertion in sim).
- Output:
  - dec_valid = head ready; dec_pc/dec_instr = head entry.
  - dec_valid & dec_ready: rd_ptr++ next cycle.
  - Outputs hold stable while dec_valid & ~dec_ready.
- Latency: request accepted in cycle N, response in cycle M >= N+1, dec_valid in M+1 (registered fill). Throughput 1/cycle with a 1-cycle memory.
- Flush (priority over everything except rst):
  - All pointers <= 0.
  - drop_cnt <= drop_cnt + outstanding - (imem_rsp_valid ? 1 : 0).
  - A response arriving in the flush cycle is discarded.
  - No request issues in the flush cycle.
  - dec_valid is 0 the cycle after flush.
- Simultaneous events:
  - Push-on-full is impossible: issue is gated by full.
  - Fill and read in the same cycle are both honoured.
  - Decode read with empty queue: no effect.
- Reset:
  - All pointers and drop_cnt <= 0.
  - dec_valid = 0, imem_req_valid = 0, pc_stall = 1 while rst is high.
  - Reset mid-operation abandons in-flight responses without drop tracking; the memory is reset by the same rst.

Optional Feature:
- IFQ_BYPASS_EN defined:
  - When rd_ptr == fill_ptr, outstanding != 0, drop_cnt == 0, ~flush and imem_rsp_valid: dec_valid = 1 combinationally in the response cycle, with dec_pc = pc_q[rd], dec_instr = imem_rsp_data.
  - If dec_ready is also high, the entry is filled and read in the same cycle (both pointers advance).
  - Otherwise it is stored normally.
  - Latency response -> decode becomes 0 cycles.
- Undefined: no combinational path from imem_rsp_* to dec_*; latency 1 cycle.

Test Plan:
- Streaming: 1-cycle memory, dec_ready=1, PC 0x0,0x4,0x8 -> dec outputs (0x0,I0),(0x4,I1),(0x8,I2) on consecutive cycles, one cycle after each response; pc_stall never asserted.
- Full: dec_ready=0, DEPTH=4, fetch 0x100..0x10C -> 4 requests, then full; pc_stall=1, imem_req_valid=0; one dec_ready pulse pops 0x100 and the next cycle issues 0x110.
- Memory backpressure: imem_req_ready=0 for 3 cycles -> pc_stall=1, PC holds, no entry allocated; resumes on ready.
- Flush with 2 in flight: flush while outstanding=2 and 1 queued -> dec_valid=0 next cycle; the next 2 responses are dropped; the first post-flush fetch 0x200 returns as (0x200, its instr).
- Flush coinciding with a response: outstanding=3, rsp_valid in flush cycle -> drop_cnt=2; exactly 2 later responses discarded.
- Reset mid-stream: rst with 3 entries queued -> dec_valid=0, pc_stall=1 during rst; pointers 0 after; first fetch from the reset vector delivered correctly.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue: issues in-order imem requests for the incoming PC,
// pairs each returned instruction with its PC and hands {pc, instr} to decode.
// Optional build macro IFQ_BYPASS_EN: forwards a response straight to decode
// in its arrival cycle when the queue head is waiting on exactly that response.
module ifu_fetch_queue #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_WIDTH-1:0]    pc_in,
  input  logic                   pc_in_valid,
  output logic                   pc_stall,
  input  logic                   flush,
  output logic                   imem_req_valid,
  output logic [PC_WIDTH-1:0]    imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   dec_valid,
  output logic [PC_WIDTH-1:0]    dec_pc,
  output logic [INSTR_WIDTH-1:0] dec_instr,
  input  logic                   dec_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = AW + 2;

  logic [PC_WIDTH-1:0]    pc_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_q [DEPTH];

  logic [PW-1:0] alloc_ptr, fill_ptr, rd_ptr;
  logic [DW-1:0] drop_cnt;

  logic [PW-1:0] occ, outstanding;
  logic [DW-1:0] drop_sum, drop_nxt;
  logic          full, head_rdy, req_fire, rsp_drop, rsp_fill, rd_fire;
`ifdef IFQ_BYPASS_EN
  logic          byp;
`endif

  assign imem_req_addr = pc_in;

  // Occupancy, issue handshake, PC stall and response classification
  always_comb begin
    occ            = alloc_ptr - rd_ptr;
    outstanding    = alloc_ptr - fill_ptr;
    full           = (occ == PW'(DEPTH));
    head_rdy       = (rd_ptr != fill_ptr);
    imem_req_valid = pc_in_valid & ~full & ~flush & ~rst;
    req_fire       = imem_req_valid & imem_req_ready;
    pc_stall       = rst | flush | full | ~imem_req_ready;
    rsp_drop       = imem_rsp_valid & (drop_cnt != '0) & ~flush & ~rst;
    rsp_fill       = imem_rsp_valid & (drop_cnt == '0) & (outstanding != '0)
                     & ~flush & ~rst;
    // On flush every in-flight fetch becomes a pending drop, minus the one
    // response (if any) that is discarded in the flush cycle itself.
    drop_sum       = drop_cnt + DW'(outstanding);
    drop_nxt       = (imem_rsp_valid && (drop_sum != '0)) ? drop_sum - DW'(1) : drop_sum;
  end

  // Decode-side view of the head entry
  always_comb begin
    dec_pc = pc_q[rd_ptr[AW-1:0]];
`ifdef IFQ_BYPASS_EN
    byp       = ~rst & ~flush & imem_rsp_valid & ~head_rdy
                & (outstanding != '0) & (drop_cnt == '0);
    dec_valid = (~rst & head_rdy) | byp;
    dec_instr = byp ? imem_rsp_data : instr_q[rd_ptr[AW-1:0]];
`else
    dec_valid = ~rst & head_rdy;
    dec_instr = instr_q[rd_ptr[AW-1:0]];
`endif
    rd_fire = dec_valid & dec_ready & ~flush;
  end

  // Pointer and drop-counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      drop_cnt  <= '0;
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      drop_cnt  <= drop_nxt;
    end else begin
      if (req_fire) alloc_ptr <= alloc_ptr + PW'(1);
      if (rsp_fill) fill_ptr  <= fill_ptr + PW'(1);
      if (rd_fire)  rd_ptr    <= rd_ptr + PW'(1);
      if (rsp_drop) drop_cnt  <= drop_cnt - DW'(1);
    end
  end

  // Entry payload storage; contents are qualified by the pointers
  always_ff @(posedge clk) begin
    if (req_fire) pc_q[alloc_ptr[AW-1:0]]   <= pc_in;
    if (rsp_fill) instr_q[fill_ptr[AW-1:0]] <= imem_rsp_data;
  end

  // A response with nothing in flight and nothing to drop is a memory protocol error
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && (outstanding == '0) && (drop_cnt == '0)));
    end
  end

endmodule
